// File: rtl/shift_pkg.sv
// Shared types and constants for the parallel-in/serial-out shift serializer.
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB   = 1'b0;
    localparam logic DIR_MSB   = 1'b1;
    localparam int   WIDTH_MIN = 1;
    localparam int   WIDTH_MAX = 1024;

endpackage

// File: rtl/shift_beat_counter.sv
// Beat down-counter: clear beats load, load beats decrement, saturates at zero.
// Latency: count and zero flag update one cycle after the command.
// Backpressure: none; the caller gates dec with the accepted beat.
module shift_beat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_serializer.sv
// Parallel-in/serial-out serializer: one word in, WIDTH bits out, MSB- or LSB-first.
// Latency: first bit valid the cycle after load accept; back-to-back words with no bubble.
// Backpressure: ser_ready stalls hold all state; load_ready only in IDLE or on the last beat.
module piso_shift_serializer
    import shift_pkg::*;
#(
    parameter int   WIDTH    = 32,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_msb_first,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("piso_shift_serializer: WIDTH out of range 1..1024");
    end

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             beat;
    logic             last_beat;
    logic             accept;

    assign beat       = ser_valid & ser_ready;
    assign last_beat  = beat & cnt_zero;
    assign load_ready = ~abort & ((state == ST_IDLE) | last_beat);
    assign accept     = load_valid & load_ready;

    // Shift toward the head bit; the vacated tail takes FILL_BIT.
    always_comb begin
        sreg_shifted = sreg;
        if (dir_q == DIR_MSB) begin
            sreg_shifted    = sreg << 1;
            sreg_shifted[0] = FILL_BIT;
        end else begin
            sreg_shifted          = sreg >> 1;
            sreg_shifted[WIDTH-1] = FILL_BIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sreg  <= '0;
            dir_q <= DIR_MSB;
        end else if (abort) begin
            state <= ST_IDLE;
            sreg  <= '0;
        end else if (accept) begin
            state <= ST_SHIFT;
            sreg  <= load_data;
            dir_q <= load_msb_first;
        end else if (last_beat) begin
            // Clearing the register keeps ser_out low while idle.
            state <= ST_IDLE;
            sreg  <= '0;
        end else if (beat) begin
            sreg  <= sreg_shifted;
        end
    end

    shift_beat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (abort),
        .load     (accept),
        .load_val (CNT_W'(WIDTH - 1)),
        .dec      (beat),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign ser_valid = (state == ST_SHIFT);
    assign busy      = (state == ST_SHIFT);
    assign ser_out   = (dir_q == DIR_MSB) ? sreg[WIDTH-1] : sreg[0];
    assign ser_last  = ser_valid & cnt_zero;

endmodule
